// File: rtl/relay_nibble_fifo.sv
// Elastic nibble FIFO feeding a fixed-rate MSB-first bit serializer for the relay
// modulation path; absorbs link jitter and flags overflow and underrun.
`timescale 1ns/1ps

module relay_nibble_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int BIT_PERIOD  = 16,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          nib_in,
  input  logic                nib_valid,
  output logic                bit_out,
  output logic                bit_strobe,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                underrun,
  output logic                busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DIV_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(BIT_PERIOD - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   PRIME_LVL = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0]   PTR_ONE   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]            shreg_q, shreg_d;
  logic [1:0]            idx_q, idx_d;
  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;
  logic                  strobe_q, strobe_d;
  logic [3:0]            fifo_mem [DEPTH];

  logic [DEPTH_LOG2:0]   level_w;
  logic                  full;
  logic                  boundary;
  logic                  pop;
  logic                  push;

  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign full     = (level_w == FULL_LVL);
  assign boundary = (div_q == DIV_LAST);

  // Pops happen only at bit boundaries and see the occupancy before this cycle's write.
  always_comb begin
    state_d    = state_q;
    div_d      = boundary ? '0 : div_q + DIV_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    underrun_d = 1'b0;
    strobe_d   = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (level_w != '0) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (boundary && (level_w >= PRIME_LVL)) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (boundary) begin
          if (idx_q != 2'd0) begin
            idx_d    = idx_q - 2'd1;
            strobe_d = 1'b1;
          end else if (level_w != '0) begin
            pop = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shreg_d  = fifo_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      idx_d    = 2'd3;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      strobe_d = 1'b1;
    end

    push = nib_valid && (!full || pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (nib_valid && !push) overflow_d = 1'b1;

    // Flush wins over everything, including a nibble arriving this cycle.
    if (!enable) begin
      state_d    = ST_IDLE;
      div_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      shreg_d    = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
      strobe_d   = 1'b0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      strobe_q   <= strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= nib_in;
  end

  assign bit_out    = (state_q == ST_SHIFT) && shreg_q[idx_q];
  assign bit_strobe = strobe_q;
  assign level      = level_w;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/relay_nibble_fifo.md
# relay_nibble_fifo

Elastic buffer and re-serializer between the relay link nibble decoder and the relay mode/modulation logic. Accepts 4-bit nibbles as single-cycle strobes at an irregular arrival rate and replays them as a steady MSB-first bit stream at a fixed bit period. It absorbs link jitter and reports overflow and underrun. In FAKE_READER/FAKE_TAG operation, its output bit drives the modulation path in place of a direct shift of the decoded nibble.

## Interface
- DEPTH_LOG2, 3: log2 of FIFO depth in nibbles (8 entries).
- BIT_PERIOD, 16: clk cycles per output bit; legal range 2..256.
- PRIME_LEVEL, 2: FIFO occupancy required before the serializer starts; legal range 1..2^DEPTH_LOG2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  active-low asynchronous reset.
- enable  in  1  block enable; low means synchronous flush.
- nib_in  in  4  decoded nibble, bit 3 first on the wire.
- nib_valid  in  1  one-cycle strobe; nib_in is valid in that cycle.
- bit_out  out  1  serialized output bit, held for BIT_PERIOD cycles.
- bit_strobe  out  1  one-cycle pulse in the first cycle of each new bit_out value while in SHIFT.
- level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky; a nibble was dropped because the FIFO was full.
- underrun  out  1  one-cycle pulse when a stream ends with the FIFO empty.
- busy  out  1  high in PRIME or SHIFT.

## Operation
- **FIFO:** circular buffer of 2^DEPTH_LOG2 × 4 bits. Write and read pointers are DEPTH_LOG2+1 bits wide with natural wrap. level = wr_ptr − rd_ptr, modulo 2^(DEPTH_LOG2+1).
- **Write:** on nib_valid && enable && (not full || read this cycle). A simultaneous read frees the slot, so writing at full is accepted when a read occurs in the same cycle.
- **Dropped write:** nib_valid at full with no read drops the nibble and sets overflow. overflow clears only on reset or when enable is low.
- **Divider:** div counts 0..BIT_PERIOD−1 and wraps while enable is high. A bit boundary is the cycle in which div == BIT_PERIOD−1.
- **IDLE state:** bit_out = 0. Go to PRIME when level ≥ 1.
- **PRIME state:** wait until level ≥ PRIME_LEVEL and a bit boundary occurs. At that boundary, pop one nibble into the shift register, set bit index to 3, and go to SHIFT.
- **SHIFT state:** bit_out = shreg[idx]. At each bit boundary:
  - If idx > 0, decrement idx.
  - If idx == 0 and level ≥ 1, pop the next nibble, set idx to 3, and stay in SHIFT (gapless).
  - If idx == 0 and level == 0, pulse underrun and go to IDLE.
- **Read rule:** a read (pop) happens only at a bit boundary, as described above. Reads on an empty FIFO never occur.
- **enable low (synchronous flush):** pointers = 0, state IDLE, div = 0, overflow = 0, bit_out = 0. Incoming nib_valid is ignored.
- **reset asserted:** same values as a flush, applied asynchronously; all outputs go to 0.

## Timing
- Reset and flush values: bit_out = 0, bit_strobe = 0, level = 0, overflow = 0, underrun = 0, busy = 0.
- **Write latency:** level increments in the cycle after the nib_valid edge.
- **Bit output:** first bit appears on bit_out in the cycle after the PRIME→SHIFT boundary, with bit_strobe high in that same cycle.
- **Bit hold:** each bit lasts exactly BIT_PERIOD cycles. Back-to-back nibbles produce contiguous bits with no idle cycles.
- **Start latency:** from the PRIME_LEVEL-th write to the first bit is at most BIT_PERIOD+1 cycles.
- underrun is asserted in the cycle after the final boundary, coincident with bit_out returning to 0 and busy falling.
- A nibble arriving in the same cycle as the final boundary of a drained FIFO counts as not present for that boundary decision: underrun fires and the state goes to IDLE, then to PRIME.
- **enable/nib_valid collision:** enable falling in the same cycle as nib_valid gives flush priority; the nibble is discarded.

## Test plan
- **Single stream:** reset, enable, write 0xC then 0x0 two cycles apart with BIT_PERIOD = 16, PRIME_LEVEL = 2. Expect bit_out 1,1,0,0,0,0,0,0, each held 16 cycles; underrun pulses once after the 8th bit; busy falls.
- **Overflow:** write 9 nibbles on consecutive cycles with DEPTH_LOG2 = 3 and no prior stream. Expect level to saturate at 8, overflow = 1 from the 9th write onward, and the 9th nibble absent from the output.
- **Full-with-read:** fill to 8 and time nib_valid to coincide with a boundary pop. Expect the write accepted, level to stay 8, and overflow to stay 0.
- **Gapless:** during SHIFT, feed one nibble every 4×BIT_PERIOD cycles for 10 nibbles. Expect 40 contiguous bits, no underrun, and bit_strobe every 16 cycles.
- **Flush mid-stream:** deassert enable mid-bit with level = 5. Expect level = 0, bit_out = 0, busy = 0 and overflow cleared on the next cycle. After re-enable, the first output is the new data only.
- **Async reset:** assert reset off-edge during SHIFT. Expect all outputs 0 immediately, before the next clk edge.
